// File: rtl/zigzag_input_framer.sv
// zigzag_input_framer
// Collects characters from a link into a frame buffer. When the end-of-frame
// token arrives it replays the buffered frame, followed by the token, to a
// downstream zigzag decryptor. It then waits through a short idle gap before
// it accepts the next frame.
// All outputs are registered. valid_o/data_o show what the state machine
// produced on the previous edge, which is why GAP runs one extra state cycle:
// the decryptor then sees two idle cycles after the token while busy_o is
// still high.
module zigzag_input_framer #(
  parameter int                 D_WIDTH                = 8,
  parameter int                 MAX_NOF_CHARS          = 50,
  parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = 8'hFA
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [D_WIDTH-1:0] data_i,
  input  logic               valid_i,
  input  logic               busy_i,
  output logic               busy_o,
  output logic [D_WIDTH-1:0] data_o,
  output logic               valid_o,
  output logic [8:0]         frame_len_o,
  output logic               overflow_o,
  output logic               drop_o
);

  localparam int         ADDR_W  = (MAX_NOF_CHARS > 1) ? $clog2(MAX_NOF_CHARS) : 1;
  localparam logic [8:0] MAX_CNT = 9'(MAX_NOF_CHARS);

  localparam logic [2:0] ST_COLLECT = 3'd0;
  localparam logic [2:0] ST_DISCARD = 3'd1;
  localparam logic [2:0] ST_WAIT_DS = 3'd2;
  localparam logic [2:0] ST_SEND    = 3'd3;
  localparam logic [2:0] ST_TOKEN   = 3'd4;
  localparam logic [2:0] ST_GAP     = 3'd5;

  logic [2:0]         state_q,     state_d;
  logic [8:0]         wr_cnt_q,    wr_cnt_d;
  logic [8:0]         rd_ptr_q,    rd_ptr_d;
  logic [8:0]         frame_len_q, frame_len_d;
  logic [1:0]         gap_cnt_q,   gap_cnt_d;
  logic               busy_o_q,    busy_o_d;
  logic               valid_o_q,   valid_o_d;
  logic [D_WIDTH-1:0] data_o_q,    data_o_d;
  logic               overflow_q,  overflow_d;
  logic               drop_q,      drop_d;

  logic [D_WIDTH-1:0] buf_q [MAX_NOF_CHARS];
  logic               buf_we_s;
  logic [ADDR_W-1:0]  buf_waddr_s;
  logic               char_s;
  logic               tok_s;

  // Qualify incoming traffic: zero characters are line filler and never count.
  always_comb begin
    char_s = valid_i && (data_i != {D_WIDTH{1'b0}});
    tok_s  = char_s && (data_i == START_DECRYPTION_TOKEN);
  end

  // Next-state and registered-output computation for the framing FSM.
  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_ptr_d    = rd_ptr_q;
    frame_len_d = frame_len_q;
    gap_cnt_d   = gap_cnt_q;
    valid_o_d   = 1'b0;
    data_o_d    = {D_WIDTH{1'b0}};
    overflow_d  = 1'b0;
    buf_we_s    = 1'b0;
    buf_waddr_s = wr_cnt_q[ADDR_W-1:0];

    case (state_q)
      ST_COLLECT: begin
        if (tok_s) begin
          if (wr_cnt_q != 9'd0) begin
            frame_len_d = wr_cnt_q;
            rd_ptr_d    = 9'd0;
            state_d     = ST_WAIT_DS;
          end else begin
            state_d = ST_COLLECT;
          end
        end else if (char_s) begin
          if (wr_cnt_q == MAX_CNT) begin
            // Frame too long: drop the whole frame up to its token.
            overflow_d = 1'b1;
            wr_cnt_d   = 9'd0;
            state_d    = ST_DISCARD;
          end else begin
            buf_we_s = 1'b1;
            wr_cnt_d = wr_cnt_q + 9'd1;
          end
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_DISCARD: begin
        if (tok_s) begin
          wr_cnt_d = 9'd0;
          state_d  = ST_COLLECT;
        end else begin
          state_d = ST_DISCARD;
        end
      end
      ST_WAIT_DS: begin
        if (!busy_i) begin
          state_d = ST_SEND;
        end else begin
          state_d = ST_WAIT_DS;
        end
      end
      ST_SEND: begin
        // No backpressure once the frame starts: one character per cycle.
        valid_o_d = 1'b1;
        data_o_d  = buf_q[rd_ptr_q[ADDR_W-1:0]];
        rd_ptr_d  = rd_ptr_q + 9'd1;
        if (rd_ptr_q == (frame_len_q - 9'd1)) begin
          state_d = ST_TOKEN;
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_TOKEN: begin
        valid_o_d = 1'b1;
        data_o_d  = START_DECRYPTION_TOKEN;
        gap_cnt_d = 2'd0;
        state_d   = ST_GAP;
      end
      ST_GAP: begin
        // The first GAP cycle still shows the token on the output register.
        if (gap_cnt_q == 2'd2) begin
          wr_cnt_d = 9'd0;
          state_d  = ST_COLLECT;
        end else begin
          gap_cnt_d = gap_cnt_q + 2'd1;
        end
      end
      default: begin
        wr_cnt_d = 9'd0;
        state_d  = ST_COLLECT;
      end
    endcase
  end

  // busy_o follows the state being entered; any real character seen while busy is dropped.
  always_comb begin
    busy_o_d = (state_d == ST_WAIT_DS) || (state_d == ST_SEND) ||
               (state_d == ST_TOKEN)   || (state_d == ST_GAP);
    drop_d   = char_s && busy_o_q;
  end

  // Control and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= ST_COLLECT;
      wr_cnt_q    <= 9'd0;
      rd_ptr_q    <= 9'd0;
      frame_len_q <= 9'd0;
      gap_cnt_q   <= 2'd0;
      busy_o_q    <= 1'b0;
      valid_o_q   <= 1'b0;
      data_o_q    <= {D_WIDTH{1'b0}};
      overflow_q  <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      frame_len_q <= frame_len_d;
      gap_cnt_q   <= gap_cnt_d;
      busy_o_q    <= busy_o_d;
      valid_o_q   <= valid_o_d;
      data_o_q    <= data_o_d;
      overflow_q  <= overflow_d;
      drop_q      <= drop_d;
    end
  end

  // Frame buffer storage; contents persist across frames and are not reset.
  always_ff @(posedge clk) begin
    if (buf_we_s) begin
      buf_q[buf_waddr_s] <= data_i;
    end
  end

  assign busy_o      = busy_o_q;
  assign valid_o     = valid_o_q;
  assign data_o      = data_o_q;
  assign frame_len_o = frame_len_q;
  assign overflow_o  = overflow_q;
  assign drop_o      = drop_q;

endmodule

// File: doc/zigzag_input_framer.md
ZIGZAG_INPUT_FRAMER -- requirements
Module: zigzag_input_framer

Interface
REQ-001 Parameter D_WIDTH, default 8, character width in bits.
REQ-002 Parameter MAX_NOF_CHARS, default 50, buffer depth in characters.
REQ-003 Parameter START_DECRYPTION_TOKEN, default 8'hFA, end-of-frame token value.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset is synchronous and active-high: block resets on a rising clk edge while rst_n=1.
REQ-006 data_i  input  D_WIDTH  raw character from the link.
REQ-007 valid_i  input  1  data_i qualifier, one character per cycle.
REQ-008 busy_i  input  1  busy flag from the downstream zigzag decryptor.
REQ-009 busy_o  output  1  high while the framer is not accepting characters.
REQ-010 data_o  output  D_WIDTH  character or token to the decryptor.
REQ-011 valid_o  output  1  data_o qualifier.
REQ-012 frame_len_o  output  9  character count of the last frame accepted (token excluded).
REQ-013 overflow_o  output  1  one-cycle pulse on buffer overflow.
REQ-014 drop_o  output  1  one-cycle pulse when a valid_i character is discarded while busy_o=1.

Function
REQ-015 The block SHALL implement states COLLECT, DISCARD, WAIT_DS, SEND, TOKEN, GAP; reset state COLLECT.
REQ-016 COLLECT: valid_i=1 with data_i=0 SHALL be ignored (no store, no pulse).
REQ-017 COLLECT: valid_i=1 with data_i neither 0 nor token SHALL write buf[wr_cnt] and increment the 9-bit wr_cnt.
REQ-018 COLLECT: a character arriving with wr_cnt=MAX_NOF_CHARS SHALL not be stored, SHALL pulse overflow_o next cycle, SHALL clear wr_cnt, and SHALL enter DISCARD.
REQ-019 DISCARD: all characters SHALL be ignored until a token, which returns to COLLECT with wr_cnt=0 and frame_len_o unchanged.
REQ-020 COLLECT: token with wr_cnt=0 SHALL be ignored (empty frame, state unchanged).
REQ-021 COLLECT: token with wr_cnt>0 SHALL load frame_len_o<=wr_cnt, clear rd_ptr, and enter WAIT_DS.
REQ-022 WAIT_DS: SHALL stay while busy_i=1; on busy_i=0 SHALL enter SEND.
REQ-023 SEND: each cycle SHALL drive valid_o=1, data_o=buf[rd_ptr], rd_ptr+1; after rd_ptr=frame_len_o-1 SHALL enter TOKEN; no backpressure mid-frame.
REQ-024 TOKEN: SHALL drive valid_o=1, data_o=START_DECRYPTION_TOKEN for exactly one cycle, then enter GAP.
REQ-025 GAP: SHALL hold valid_o=0 for exactly 2 cycles, then return to COLLECT with wr_cnt=0.
REQ-026 valid_o SHALL be 0 and data_o SHALL be 0 in every state other than SEND and TOKEN.
REQ-027 busy_o SHALL be 1 exactly in WAIT_DS, SEND, TOKEN, GAP (registered, asserted the cycle after the accepting token).
REQ-028 Any valid_i=1 with data_i!=0 while busy_o=1 SHALL be discarded and pulse drop_o the next cycle.
REQ-029 Latency: token accepted at edge T with busy_i=0 SHALL yield first valid_o=1 at edge T+2; N-character frame occupies N+1 valid cycles contiguously.
REQ-030 Buffer read order SHALL equal write order; buffer contents need not be cleared between frames.

Reset
REQ-031 On reset: state COLLECT, wr_cnt=0, rd_ptr=0, busy_o=0, valid_o=0, data_o=0, frame_len_o=0, overflow_o=0, drop_o=0.
REQ-032 Reset asserted mid-SEND SHALL abort the frame immediately, no token emitted; valid_o=0 the following cycle.

Verification
REQ-033 Input 'H','E','L','L','O',FA, busy_i=0 -> frame_len_o=5; valid_o two cycles after FA with 'H','E','L','L','O',FA contiguous, then 2 idle cycles, busy_o 1 throughout.
REQ-034 FA alone, then 'A',00,'B',FA -> first FA ignored; output 'A','B',FA; frame_len_o=2.
REQ-035 busy_i=1 held 10 cycles after FA of 'XY' -> no valid_o until busy_i falls; output 'X','Y',FA starting the cycle after busy_i=0 is sampled.
REQ-036 51 non-zero chars then 'Z',FA -> overflow_o pulses once after char 51; no output; next frame 'Q',FA outputs 'Q',FA with frame_len_o=1.
REQ-037 Chars arriving during SEND -> each pulses drop_o; output frame unchanged.
REQ-038 rst_n=1 for one cycle mid-SEND of 'ABCD' -> valid_o=0 next cycle, busy_o=0, frame_len_o=0, no FA emitted.
